// File: rtl/adc_channel_sequencer.sv
// ADC channel sequencer: round-robin mux stepping, settle wait, conversion
// start/capture with timeout, and per-channel averager EN / window-fill tracking.
module adc_channel_sequencer #(
    parameter int NCH         = 5,
    parameter int N           = 12,
    parameter int POWER       = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   adc_done,
    input  logic [N-1:0]           adc_data,
    input  logic                   err_clr,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   adc_start,
    output logic [N-1:0]           avg_din,
    output logic [NCH-1:0]         avg_en,
    output logic [NCH-1:0]         avg_valid,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int CH_W    = $clog2(NCH);
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NCH - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [POWER:0]   FILL_FULL   = (POWER + 1)'(2 ** POWER);
    localparam logic [POWER:0]   FILL_LAST   = (POWER + 1)'(2 ** POWER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_STORE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0]  r_ch_sel;
    logic             r_adc_start;
    logic [N-1:0]     r_avg_din;
    logic [NCH-1:0]   r_avg_en;
    logic [NCH-1:0]   r_avg_valid;
    logic             r_timeout_err;
    logic             r_busy;
    logic [POWER:0]   r_fill [NCH];

    logic [NCH-1:0]   w_ch_onehot;
    logic [CH_W-1:0]  w_ch_next;

    // Current-channel decode and round-robin successor.
    always_comb begin
        w_ch_onehot = NCH'(1) << r_ch_sel;
        w_ch_next   = (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + 1'b1;
    end

    // Sequencing FSM with registered strobes, channel select and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ch_sel      <= '0;
            r_adc_start   <= 1'b0;
            r_avg_din     <= '0;
            r_avg_en      <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_adc_start <= 1'b0;
            r_avg_en    <= '0;
            // Clear is written first so a timeout set below in the same cycle wins.
            if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CNT_SETTLE;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_CONVERT;
                        r_cnt       <= '0;
                        r_adc_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CONVERT: begin
                    // A done arriving on the last allowed cycle is still accepted.
                    if (adc_done) begin
                        r_avg_din <= adc_data;
                        r_avg_en  <= w_ch_onehot;
                        r_state   <= S_STORE;
                    end else if (r_cnt == CNT_TIMEOUT) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_STORE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    r_ch_sel <= w_ch_next;
                    if (enable) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CNT_SETTLE;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel window fill; valid rises one cycle after the EN that fills the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_fill[i] <= '0;
            end
            r_avg_valid <= '0;
        end else if (r_state == S_STORE && (|r_avg_en)) begin
            if (r_fill[r_ch_sel] != FILL_FULL) begin
                r_fill[r_ch_sel] <= r_fill[r_ch_sel] + 1'b1;
            end
            if (r_fill[r_ch_sel] == FILL_LAST) begin
                r_avg_valid <= r_avg_valid | w_ch_onehot;
            end
        end
    end

    assign ch_sel      = r_ch_sel;
    assign adc_start   = r_adc_start;
    assign avg_din     = r_avg_din;
    assign avg_en      = r_avg_en;
    assign avg_valid   = r_avg_valid;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule
